// File: rtl/prog_boot_loader.sv
// Boot/preload controller for the IITB-RISC core: streams words into instruction
// memory and the register file, then runs the core until it halts or times out.
module prog_boot_loader #(
  parameter int DATA_W      = 16,
  parameter int MEM_AW      = 6,
  parameter int NUM_REGS    = 7,
  parameter int HALT_CYCLES = 4,
  parameter int TIMEOUT     = 1024,
  parameter int RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_is_reg,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              reg_we,
  output logic [2:0]        reg_widx,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              core_rst_n,
  output logic [DATA_W-1:0] pc_init,
  input  logic [DATA_W-1:0] core_pc,
  output logic              busy,
  output logic              halted,
  output logic              timeout,
  output logic              addr_err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  HALT_LIM = CNT_W'(HALT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TOUT_LIM = CNT_W'(TIMEOUT - 1);
  localparam logic [MEM_AW:0]   REG_LIM  = (MEM_AW + 1)'(NUM_REGS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DONE, S_TOUT} state_t;

  state_t            r_state, w_state_next;
  logic              r_drain;
  logic              r_run_first;
  logic [DATA_W-1:0] r_prev_pc;
  logic [CNT_W-1:0]  r_stall_cnt, r_wd_cnt;
  logic [CNT_W-1:0]  w_stall_next;
  logic              w_accept, w_reg_ok, w_halt, w_tout, w_restart;

  assign pc_init   = DATA_W'(RESET_PC);
  assign w_accept  = ld_valid & ld_ready;
  assign w_reg_ok  = {1'b0, ld_addr} < REG_LIM;
  assign w_restart = start & (r_state inside {S_IDLE, S_DONE, S_TOUT});

  // The entry cycle only captures core_pc, so it never counts as a repeat.
  assign w_stall_next = (r_run_first || core_pc != r_prev_pc) ? '0 : r_stall_cnt + 1'b1;
  assign w_halt       = (r_state == S_RUN) && (w_stall_next == HALT_LIM);
  assign w_tout       = (r_state == S_RUN) && (r_wd_cnt == TOUT_LIM);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    ld_ready     = 1'b0;
    core_rst_n   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_LOAD;
      S_LOAD: begin
        // The cycle after the last word is accepted carries its write; stop accepting.
        ld_ready = ~r_drain;
        busy     = 1'b1;
        if (r_drain) w_state_next = S_RUN;
      end
      S_RUN: begin
        core_rst_n = 1'b1;
        busy       = 1'b1;
        if (w_halt)      w_state_next = S_DONE;
        else if (w_tout) w_state_next = S_TOUT;
      end
      S_DONE, S_TOUT: if (start) w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_drain     <= 1'b0;
      r_run_first <= 1'b1;
      r_prev_pc   <= '0;
      r_stall_cnt <= '0;
      r_wd_cnt    <= '0;
      mem_we      <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_widx    <= '0;
      reg_wdata   <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_drain <= w_accept & ld_last;
      mem_we  <= w_accept & ~ld_is_reg;
      reg_we  <= w_accept & ld_is_reg & w_reg_ok;

      if (w_accept && !ld_is_reg) begin
        mem_waddr <= ld_addr;
        mem_wdata <= ld_data;
      end
      if (w_accept && ld_is_reg && w_reg_ok) begin
        reg_widx  <= ld_addr[2:0];
        reg_wdata <= ld_data;
      end

      if (w_restart) begin
        halted   <= 1'b0;
        timeout  <= 1'b0;
        addr_err <= 1'b0;
      end else begin
        if (w_accept && ld_is_reg && !w_reg_ok) addr_err <= 1'b1;
        if (w_halt)      halted  <= 1'b1;
        else if (w_tout) timeout <= 1'b1;
      end

      if (r_state == S_RUN) begin
        r_run_first <= 1'b0;
        r_prev_pc   <= core_pc;
        r_stall_cnt <= w_stall_next;
        r_wd_cnt    <= r_wd_cnt + 1'b1;
      end else begin
        r_run_first <= 1'b1;
        r_stall_cnt <= '0;
        r_wd_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prog_boot_loader.sv
// Directed bench for prog_boot_loader: load sessions, halt, watchdog and
// mid-load reset, with hand-computed expectations.
module tb_prog_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, ld_valid, ld_is_reg, ld_last;
  logic        ld_ready;
  logic [5:0]  ld_addr;
  logic [15:0] ld_data;
  logic        mem_we, reg_we, core_rst_n, busy, halted, timeout, addr_err;
  logic [5:0]  mem_waddr;
  logic [15:0] mem_wdata, reg_wdata, pc_init, core_pc;
  logic [2:0]  reg_widx;

  int n_checks = 0;
  int n_errors = 0;
  int mem_pulses = 0;
  int reg_pulses = 0;

  prog_boot_loader #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_is_reg(ld_is_reg),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .reg_we(reg_we), .reg_widx(reg_widx), .reg_wdata(reg_wdata),
    .core_rst_n(core_rst_n), .pc_init(pc_init), .core_pc(core_pc),
    .busy(busy), .halted(halted), .timeout(timeout), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample 1 ns after the edge; strobes are tallied here.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_we) mem_pulses++;
    if (reg_we) reg_pulses++;
  endtask

  task automatic send(input logic is_reg, input logic [5:0] addr,
                      input logic [15:0] data, input logic last);
    ld_valid  = 1'b1;
    ld_is_reg = is_reg;
    ld_addr   = addr;
    ld_data   = data;
    ld_last   = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 64; i++) begin
      if (!busy) break;
      tick();
    end
    check(tag, busy, 0);
  endtask

  logic [15:0] reg_vals [7] = '{16'd1, 16'd2, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
  logic [15:0] halt_pcs [7] = '{16'd0, 16'd1, 16'd2, 16'd5, 16'd5, 16'd5, 16'd5};

  initial begin
    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_is_reg = 1'b0;
    ld_addr = '0; ld_data = '0; ld_last = 1'b0; core_pc = '0;
    tick();
    tick();
    check("rst_ld_ready", ld_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {halted, timeout, addr_err}, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_mem_bus", {mem_waddr, mem_wdata}, 0);
    check("rst_reg_bus", {reg_widx, reg_wdata}, 0);
    check("pc_init", pc_init, 0);
    rst_n = 1'b1;
    tick();
    check("idle_stays", busy, 0);

    // Three instruction words; strobe must appear exactly one cycle after acceptance.
    start_session();
    check("load_ready", ld_ready, 1);
    check("load_core_rst", core_rst_n, 0);
    mem_pulses = 0;
    send(1'b0, 6'd0, 16'h3002, 1'b0);
    check("m0_we", mem_we, 1);
    check("m0_bus", {mem_waddr, mem_wdata}, {6'd0, 16'h3002});
    send(1'b0, 6'd1, 16'h3202, 1'b0);
    check("m1_bus", {mem_we, mem_waddr, mem_wdata}, {1'b1, 6'd1, 16'h3202});
    send(1'b0, 6'd7, 16'h904C, 1'b1);
    check("m7_bus", {mem_we, mem_waddr, mem_wdata}, {1'b1, 6'd7, 16'h904C});
    check("drain_ready", ld_ready, 0);
    check("drain_core_rst", core_rst_n, 0);
    tick();
    check("run_strobe_off", mem_we, 0);
    check("run_core_rst", core_rst_n, 1);
    check("mem_pulse_count", mem_pulses, 3);
    wait_done("s1_done");
    check("s1_halted", halted, 1);

    // Register load r0..r6 followed by a final memory word.
    start_session();
    check("s2_halt_cleared", halted, 0);
    reg_pulses = 0;
    for (int i = 0; i < 7; i++) begin
      send(1'b1, 6'(i), reg_vals[i], 1'b0);
      check($sformatf("r%0d_we", i), {reg_we, mem_we}, 2'b10);
      check($sformatf("r%0d_bus", i), {reg_widx, reg_wdata}, {3'(i), reg_vals[i]});
    end
    send(1'b0, 6'd10, 16'h0001, 1'b1);
    check("s2_last_mem", {mem_we, reg_we, mem_waddr}, {1'b1, 1'b0, 6'd10});
    tick();
    check("reg_pulse_count", reg_pulses, 7);
    check("s2_addr_err", addr_err, 0);
    wait_done("s2_done");

    // Out-of-range register index is dropped and flagged; later words still land.
    start_session();
    reg_pulses = 0;
    send(1'b1, 6'd7, 16'hBEEF, 1'b0);
    check("bad_idx_strobes", {reg_we, mem_we}, 2'b00);
    check("bad_idx_err", addr_err, 1);
    send(1'b1, 6'd2, 16'h0022, 1'b0);
    check("after_err_reg", {reg_we, reg_widx, reg_wdata}, {1'b1, 3'd2, 16'h0022});
    send(1'b0, 6'd3, 16'hABCD, 1'b1);
    check("after_err_mem", {mem_we, mem_waddr, mem_wdata}, {1'b1, 6'd3, 16'hABCD});
    check("s3_reg_pulses", reg_pulses, 1);
    wait_done("s3_done");
    check("s3_err_sticky", addr_err, 1);

    // Halt: PC 0,1,2 then 5 held for four cycles.
    start_session();
    check("s4_err_cleared", addr_err, 0);
    send(1'b0, 6'd0, 16'h0001, 1'b1);
    tick();
    check("s4_run", core_rst_n, 1);
    for (int i = 0; i < 7; i++) begin
      core_pc = halt_pcs[i];
      if (i == 6) check("pre_halt", {busy, halted}, 2'b10);
      tick();
    end
    check("halt_flags", {halted, timeout}, 2'b10);
    check("halt_frozen", {busy, core_rst_n}, 2'b00);

    // Watchdog: PC never repeats, fires at the end of the 16th RUN cycle.
    start_session();
    send(1'b0, 6'd0, 16'h0001, 1'b1);
    tick();
    for (int k = 1; k <= 16; k++) begin
      core_pc = 16'(k);
      if (k == 16) check("pre_tout", {busy, timeout}, 2'b10);
      tick();
    end
    check("tout_flags", {halted, timeout}, 2'b01);
    check("tout_frozen", {busy, core_rst_n}, 2'b00);

    // Reset in the middle of a load session.
    start_session();
    check("s6_tout_cleared", timeout, 0);
    send(1'b0, 6'd4, 16'h1111, 1'b0);
    send(1'b0, 6'd5, 16'h2222, 1'b0);
    check("pre_rst_mem", {mem_we, mem_waddr}, {1'b1, 6'd5});
    rst_n = 1'b0;
    send(1'b0, 6'd6, 16'h3333, 1'b0);
    check("midrst_strobes", {mem_we, reg_we}, 2'b00);
    check("midrst_idle", {busy, ld_ready, core_rst_n}, 3'b000);
    check("midrst_bus", mem_waddr, 0);
    rst_n = 1'b1;
    tick();
    check("midrst_stay_idle", busy, 0);
    start_session();
    send(1'b0, 6'd2, 16'h1234, 1'b1);
    check("reload_mem", {mem_we, mem_waddr, mem_wdata}, {1'b1, 6'd2, 16'h1234});
    tick();
    check("reload_run", core_rst_n, 1);
    wait_done("s6_done");
    check("s6_halted", halted, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_boot_loader.md
Name: prog_boot_loader

Overview:
- Parametrised boot/preload controller for the 16-bit IITB-RISC pipelined core.
- Replaces direct hierarchical preloading of the instruction memory, register file, `PC` and `taken_branch` with a synthesizable, handshaken load stream.
- Holds the core in reset while loading, then releases it and watches `PC` for a halt (self-loop) or a watchdog timeout.
- Sits between a host/UART-style word source and the core's memory and register-file write ports.

Parameters:
- DATA_W, 16, instruction/register word width
- MEM_AW, 6, instruction-memory address width (depth = 2^MEM_AW)
- NUM_REGS, 7, architectural registers loadable (index 0..NUM_REGS-1)
- HALT_CYCLES, 4, consecutive cycles with unchanged core_pc that signal a halt
- TIMEOUT, 1024, maximum RUN cycles before the watchdog fires
- RESET_PC, 0, PC value presented to the core at release

Ports:
- clk, in, 1, system clock; all state changes on the rising edge
- rst_n, in, 1, synchronous active-low reset
- start, in, 1, one-cycle pulse that begins a load session
- ld_valid, in, 1, load word valid
- ld_ready, out, 1, loader accepts a word this cycle
- ld_is_reg, in, 1, 1 = register-file target, 0 = instruction-memory target
- ld_addr, in, MEM_AW, memory address, or register index in the low bits
- ld_data, in, DATA_W, word to write
- ld_last, in, 1, marks the final word of the session
- mem_we, out, 1, instruction-memory write strobe
- mem_waddr, out, MEM_AW, memory write address
- mem_wdata, out, DATA_W, memory write data
- reg_we, out, 1, register-file write strobe
- reg_widx, out, 3, register write index
- reg_wdata, out, DATA_W, register write data
- core_rst_n, out, 1, core reset (active low)
- pc_init, out, DATA_W, PC load value (RESET_PC)
- core_pc, in, DATA_W, core program counter
- busy, out, 1, high in LOAD or RUN
- halted, out, 1, sticky, set on halt detection
- timeout, out, 1, sticky, set on watchdog expiry
- addr_err, out, 1, sticky, set on an out-of-range register index

Behaviour:
- Reset (rst_n=0 at posedge):
  - state = IDLE.
  - ld_ready, mem_we, reg_we, busy, halted, timeout, addr_err = 0.
  - core_rst_n = 0.
  - mem_waddr, mem_wdata, reg_widx, reg_wdata = 0.
  - Counters cleared.
- Reset applied in any state aborts that state the same way; no write issues in the reset cycle.
- pc_init is constant RESET_PC.
- States: IDLE, LOAD, RUN, DONE, TOUT.
- IDLE:
  - core_rst_n=0, ld_ready=0.
  - start=1 → LOAD.
  - On that transition, clear halted, timeout and addr_err.
- LOAD:
  - ld_ready=1 and core_rst_n=0.
  - A word is accepted when ld_valid & ld_ready.
  - Accepted word, ld_is_reg=0: next cycle mem_we=1, mem_waddr=ld_addr, mem_wdata=ld_data.
  - Accepted word, ld_is_reg=1 and ld_addr<NUM_REGS: next cycle reg_we=1, reg_widx=ld_addr[2:0].
  - Accepted word, ld_is_reg=1 and ld_addr>=NUM_REGS: word dropped, addr_err set, no strobe.
  - Strobes are one cycle wide; write latency is exactly 1 cycle after acceptance.
  - One word per cycle maximum; back-to-back acceptance allowed.
  - An accepted word with ld_last=1 → RUN after its write.
  - start during LOAD is ignored.
- RUN:
  - core_rst_n=1 from the first RUN cycle, ld_ready=0.
  - Stall counter: increments when core_pc equals its previous-cycle value, else resets to 0.
  - Stall counter reaching HALT_CYCLES-1 → halted=1, state DONE.
  - Watchdog counter increments every RUN cycle; reaching TIMEOUT-1 → timeout=1, state TOUT.
  - Halt and watchdog in the same cycle: halt wins (halted=1, timeout=0).
  - Previous-PC register is initialised to core_pc on RUN entry, so the entry cycle does not count as a repeat.
- DONE / TOUT:
  - core_rst_n=0 (core frozen), busy=0, flags held.
  - start → LOAD; flags clear as in IDLE.
- Counter widths: clog2(TIMEOUT)+1 bits; no wrap possible before the compare fires.

Test Plan:
- Load mem[0]=16'h3002, mem[1]=16'h3202, mem[7]=16'h904C (ld_last on the last word) → exactly three mem_we pulses, each 1 cycle after acceptance, with the matching addresses/data; then RUN and core_rst_n=1.
- Register load r0..r6 = 1,2,2,3,4,5,6, then one mem word with ld_last → reg_we pulses for idx 0..6 with those values; addr_err=0.
- Register index 7 with ld_is_reg=1 → no reg_we, addr_err=1; subsequent valid words are still written.
- RUN with core_pc stepping 0,1,2 then holding 5 for 4 cycles → halted=1 on the 4th equal cycle, state DONE, core_rst_n=0.
- TIMEOUT=16, core_pc incrementing every cycle → timeout=1 at the 16th RUN cycle, halted=0.
- rst_n=0 mid-LOAD after 2 accepted words → all strobes 0 next cycle, state IDLE; a new start reloads cleanly.
